// File: rtl/pong_game_engine.sv
// Pong game-state engine: paddles, ball motion, reflection, scoring and serve/game-over flow,
// advanced on frame ticks derived from the falling edge of vSync.
module pong_game_engine #(
  parameter int BIT_WIDTH       = 10,
  parameter int BALL_RADIUS     = 0,
  parameter int PADDLE_WIDTH    = 0,
  parameter int PADDLE_LENGTH   = 2,
  parameter int GRID_W          = 32,
  parameter int GRID_H          = 24,
  parameter int P1_X            = 1,
  parameter int P2_X            = 30,
  parameter int FRAMES_PER_STEP = 4,
  parameter int SERVE_FRAMES    = 60,
  parameter int WIN_SCORE       = 7
) (
  input  logic                 clk,
  input  logic                 sysRst,
  input  logic                 vSync,
  input  logic                 p1Up,
  input  logic                 p1Down,
  input  logic                 p2Up,
  input  logic                 p2Down,
  input  logic                 start,
  output logic [BIT_WIDTH-1:0] ball_x,
  output logic [BIT_WIDTH-1:0] ball_y,
  output logic [BIT_WIDTH-1:0] player1_x,
  output logic [BIT_WIDTH-1:0] player1_y,
  output logic [BIT_WIDTH-1:0] player2_x,
  output logic [BIT_WIDTH-1:0] player2_y,
  output logic [3:0]           score1,
  output logic [3:0]           score2,
  output logic                 gameOver,
  output logic                 winner
);

  typedef logic [BIT_WIDTH-1:0] coord_t;
  typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_POINT, ST_GAMEOVER} state_t;

  localparam int FRAME_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int SERVE_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_STEP - 1);
  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [SERVE_W-1:0] SERVE_ONE  = SERVE_W'(1);

  localparam coord_t ONE       = coord_t'(1);
  localparam coord_t CENTER_X  = coord_t'(GRID_W / 2);
  localparam coord_t CENTER_Y  = coord_t'(GRID_H / 2);
  localparam coord_t X_LO_EDGE = coord_t'(BALL_RADIUS);
  localparam coord_t X_HI_EDGE = coord_t'(GRID_W - 1 - BALL_RADIUS);
  localparam coord_t Y_LO_EDGE = coord_t'(BALL_RADIUS);
  localparam coord_t Y_HI_EDGE = coord_t'(GRID_H - 1 - BALL_RADIUS);
  localparam coord_t P1_HIT_X  = coord_t'(P1_X + PADDLE_WIDTH + 1 + BALL_RADIUS);
  localparam coord_t P2_HIT_X  = coord_t'(P2_X - 1 - BALL_RADIUS);
  localparam coord_t PAD_MIN   = coord_t'(PADDLE_LENGTH);
  localparam coord_t PAD_MAX   = coord_t'(GRID_H - 1 - PADDLE_LENGTH);
  localparam coord_t HIT_SPAN  = coord_t'(PADDLE_LENGTH + BALL_RADIUS);
  localparam logic [3:0] WIN   = 4'(WIN_SCORE);

  state_t             state_q, state_d;
  coord_t             ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  coord_t             p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic               dx_pos_q, dx_pos_d, dy_pos_q, dy_pos_d;
  logic [3:0]         score1_q, score1_d, score2_q, score2_d;
  logic               winner_q, winner_d;
  logic               scorer_q, scorer_d;
  logic               vsync_q, vsync_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [SERVE_W-1:0] serve_q, serve_d;

  logic       tick, step;
  logic       miss_l, miss_r, hit1, hit2, wall_hit, new_dx, new_dy;
  logic [3:0] score_inc;

  function automatic coord_t move_paddle(input coord_t y, input logic up, input logic dn);
    move_paddle = y;
    if (up && !dn && y > PAD_MIN)
      move_paddle = y - ONE;
    else if (dn && !up && y < PAD_MAX)
      move_paddle = y + ONE;
  endfunction

  // Distance test ordered so the unsigned subtraction never wraps.
  function automatic logic in_reach(input coord_t by, input coord_t py);
    if (by >= py)
      in_reach = (by - py) <= HIT_SPAN;
    else
      in_reach = (py - by) <= HIT_SPAN;
  endfunction

  always_comb begin
    tick = vsync_q & ~vSync;
    step = tick && (frame_q == FRAME_LAST);

    miss_l   = !dx_pos_q && (ball_x_q == X_LO_EDGE);
    miss_r   =  dx_pos_q && (ball_x_q == X_HI_EDGE);
    hit1     = !dx_pos_q && (ball_x_q == P1_HIT_X) && in_reach(ball_y_q, p1_y_q);
    hit2     =  dx_pos_q && (ball_x_q == P2_HIT_X) && in_reach(ball_y_q, p2_y_q);
    wall_hit = dy_pos_q ? (ball_y_q == Y_HI_EDGE) : (ball_y_q == Y_LO_EDGE);
    new_dx   = dx_pos_q ^ (hit1 | hit2);
    new_dy   = dy_pos_q ^ wall_hit;
    score_inc = (scorer_q ? score2_q : score1_q) + 4'd1;

    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    p1_y_d   = p1_y_q;
    p2_y_d   = p2_y_q;
    dx_pos_d = dx_pos_q;
    dy_pos_d = dy_pos_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    scorer_d = scorer_q;
    vsync_d  = vSync;
    frame_d  = frame_q;
    serve_d  = serve_q;

    if (tick)
      frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_ONE;

    case (state_q)
      ST_SERVE: begin
        if (step) begin
          p1_y_d = move_paddle(p1_y_q, p1Up, p1Down);
          p2_y_d = move_paddle(p2_y_q, p2Up, p2Down);
        end
        if (tick) begin
          if (serve_q == SERVE_LAST) begin
            serve_d = '0;
            state_d = ST_PLAY;
          end else begin
            serve_d = serve_q + SERVE_ONE;
          end
        end
      end

      ST_PLAY: begin
        if (step) begin
          p1_y_d = move_paddle(p1_y_q, p1Up, p1Down);
          p2_y_d = move_paddle(p2_y_q, p2Up, p2Down);
          if (miss_l || miss_r) begin
            scorer_d = miss_l;
            state_d  = ST_POINT;
          end else begin
            dx_pos_d = new_dx;
            dy_pos_d = new_dy;
            ball_x_d = new_dx ? ball_x_q + ONE : ball_x_q - ONE;
            ball_y_d = new_dy ? ball_y_q + ONE : ball_y_q - ONE;
          end
        end
      end

      ST_POINT: begin
        if (scorer_q)
          score2_d = score_inc;
        else
          score1_d = score_inc;
        if (score_inc == WIN) begin
          winner_d = scorer_q;
          state_d  = ST_GAMEOVER;
        end else begin
          ball_x_d = CENTER_X;
          ball_y_d = CENTER_Y;
          // Serve toward the player who just lost the point.
          dx_pos_d = !scorer_q;
          dy_pos_d = 1'b1;
          state_d  = ST_SERVE;
        end
      end

      ST_GAMEOVER: begin
        if (start) begin
          score1_d = '0;
          score2_d = '0;
          winner_d = 1'b0;
          ball_x_d = CENTER_X;
          ball_y_d = CENTER_Y;
          dx_pos_d = 1'b1;
          dy_pos_d = 1'b1;
          p1_y_d   = CENTER_Y;
          p2_y_d   = CENTER_Y;
          serve_d  = '0;
          state_d  = ST_SERVE;
        end
      end

      default: state_d = ST_SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sysRst) begin
      state_q  <= ST_SERVE;
      ball_x_q <= CENTER_X;
      ball_y_q <= CENTER_Y;
      p1_y_q   <= CENTER_Y;
      p2_y_q   <= CENTER_Y;
      dx_pos_q <= 1'b1;
      dy_pos_q <= 1'b1;
      score1_q <= '0;
      score2_q <= '0;
      winner_q <= 1'b0;
      scorer_q <= 1'b0;
      vsync_q  <= 1'b1;
      frame_q  <= '0;
      serve_q  <= '0;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      p1_y_q   <= p1_y_d;
      p2_y_q   <= p2_y_d;
      dx_pos_q <= dx_pos_d;
      dy_pos_q <= dy_pos_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      winner_q <= winner_d;
      scorer_q <= scorer_d;
      vsync_q  <= vsync_d;
      frame_q  <= frame_d;
      serve_q  <= serve_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign player1_x = coord_t'(P1_X);
  assign player1_y = p1_y_q;
  assign player2_x = coord_t'(P2_X);
  assign player2_y = p2_y_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign gameOver  = (state_q == ST_GAMEOVER);
  assign winner    = winner_q;

endmodule
